// File: rtl/scan_pattern_driver.sv
// Tester-side scan pattern driver: streams pattern beats into parallel scan chains and counts masked mismatches.
// Optional first-fail logging is built when SCAN_DRIVER_FAIL_LOG_EN is defined.
module scan_pattern_driver #(
    parameter int NUM_CHAINS = 6,
    parameter int LEN_W      = 16,
    parameter int CNT_W      = 16
) (
    input  logic                  clk,
    input  logic                  ext_rst_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [LEN_W-1:0]      chain_len,
    input  logic [LEN_W-1:0]      num_loads,
    input  logic                  beat_valid,
    output logic                  beat_ready,
    input  logic [NUM_CHAINS-1:0] beat_si,
    input  logic [NUM_CHAINS-1:0] beat_exp,
    input  logic [NUM_CHAINS-1:0] beat_mask,
    input  logic [NUM_CHAINS-1:0] sdo,
    output logic                  test_en,
    output logic                  scan_en,
    output logic [NUM_CHAINS-1:0] sdi,
    output logic                  scan_clk_en,
    output logic                  busy,
    output logic                  done,
    output logic [CNT_W-1:0]      mismatch_cnt,
    output logic [1:0]            fsm_state
`ifdef SCAN_DRIVER_FAIL_LOG_EN
    ,
    output logic                  fail_seen,
    output logic [LEN_W-1:0]      fail_load,
    output logic [LEN_W-1:0]      fail_bit,
    output logic [NUM_CHAINS-1:0] fail_chains
`endif
);

    // Beat handshake: a beat is consumed in a cycle where beat_valid && beat_ready;
    // beat_ready is high only in SHIFT with no abort pending, and sdi/compare use that same cycle's beat.
    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SHIFT   = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } state_t;

    localparam int PW = $clog2(NUM_CHAINS + 1);
    localparam int SW = CNT_W + PW;

    state_t                state, next_state;
    logic [LEN_W-1:0]      len_q, loads_q, bit_cnt, load_cnt;
    logic [NUM_CHAINS-1:0] sdi_q;
    logic [NUM_CHAINS-1:0] miss;
    logic [PW-1:0]         pop;
    logic [SW-1:0]         sum;
    logic [CNT_W-1:0]      cnt_next;
    logic                  consume, last_bit, last_load, empty_req;

    assign consume   = (state == S_SHIFT) && beat_valid && !abort;
    assign last_bit  = (bit_cnt == len_q - LEN_W'(1));
    assign last_load = (load_cnt >= loads_q - LEN_W'(1));
    assign empty_req = (chain_len == '0) || (num_loads == '0);
    assign miss      = (sdo ^ beat_exp) & beat_mask;
    assign fsm_state = state;

    always_comb begin
        pop = '0;
        for (int i = 0; i < NUM_CHAINS; i++) begin
            pop = pop + PW'(miss[i]);
        end
        sum      = SW'(mismatch_cnt) + SW'(pop);
        cnt_next = (sum > SW'({CNT_W{1'b1}})) ? {CNT_W{1'b1}} : sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        if (abort) begin
            next_state = S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        next_state = empty_req ? S_DONE : S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    if (consume && last_bit) begin
                        next_state = last_load ? S_DONE : S_CAPTURE;
                    end
                end
                S_CAPTURE: next_state = S_SHIFT;
                S_DONE:    next_state = S_IDLE;
                default:   next_state = S_IDLE;
            endcase
        end
    end

    always_comb begin
        test_en     = 1'b0;
        scan_en     = 1'b0;
        scan_clk_en = 1'b0;
        beat_ready  = 1'b0;
        done        = 1'b0;
        busy        = (state != S_IDLE);
        sdi         = '0;
        case (state)
            S_SHIFT: begin
                test_en     = 1'b1;
                scan_en     = 1'b1;
                beat_ready  = !abort;
                scan_clk_en = consume;
                sdi         = consume ? beat_si : sdi_q;
            end
            S_CAPTURE: begin
                test_en     = 1'b1;
                scan_clk_en = 1'b1;
                sdi         = sdi_q;
            end
            S_DONE: begin
                test_en = 1'b1;
                done    = 1'b1;
                sdi     = sdi_q;
            end
            default: ;
        endcase
    end

    // Counters and latched session parameters; abort freezes everything including mismatch_cnt.
    always_ff @(posedge clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            len_q        <= '0;
            loads_q      <= '0;
            bit_cnt      <= '0;
            load_cnt     <= '0;
            sdi_q        <= '0;
            mismatch_cnt <= '0;
        end else if (!abort) begin
            if (state == S_IDLE && start && !empty_req) begin
                len_q        <= chain_len;
                loads_q      <= num_loads;
                bit_cnt      <= '0;
                load_cnt     <= '0;
                sdi_q        <= '0;
                mismatch_cnt <= '0;
            end else if (consume) begin
                sdi_q        <= beat_si;
                mismatch_cnt <= cnt_next;
                bit_cnt      <= last_bit ? '0 : bit_cnt + LEN_W'(1);
            end else if (state == S_CAPTURE) begin
                load_cnt <= load_cnt + LEN_W'(1);
                bit_cnt  <= '0;
            end
        end
    end

`ifdef SCAN_DRIVER_FAIL_LOG_EN
    always_ff @(posedge clk or negedge ext_rst_n) begin
        if (!ext_rst_n) begin
            fail_seen   <= 1'b0;
            fail_load   <= '0;
            fail_bit    <= '0;
            fail_chains <= '0;
        end else if (!abort) begin
            if (state == S_IDLE && start && !empty_req) begin
                fail_seen   <= 1'b0;
                fail_load   <= '0;
                fail_bit    <= '0;
                fail_chains <= '0;
            end else if (consume && !fail_seen && (miss != '0)) begin
                fail_seen   <= 1'b1;
                fail_load   <= load_cnt;
                fail_bit    <= bit_cnt;
                fail_chains <= miss;
            end
        end
    end
`endif

endmodule

// File: tb/tb_scan_pattern_driver.sv
// Directed bench for scan_pattern_driver; a second instance with CNT_W=2 shares the stimulus for saturation.
module tb_scan_pattern_driver;

    logic        clk = 1'b0;
    logic        ext_rst_n, start, abort, beat_valid;
    logic [15:0] chain_len, num_loads;
    logic [5:0]  beat_si, beat_exp, beat_mask, sdo;

    logic        beat_ready, test_en, scan_en, scan_clk_en, busy, done;
    logic [5:0]  sdi;
    logic [15:0] mismatch_cnt;
    logic [1:0]  fsm_state;

    logic        s_beat_ready, s_test_en, s_scan_en, s_scan_clk_en, s_busy, s_done;
    logic [5:0]  s_sdi;
    logic [1:0]  s_mismatch_cnt;
    logic [1:0]  s_fsm_state;

`ifdef SCAN_DRIVER_FAIL_LOG_EN
    logic        fail_seen, s_fail_seen;
    logic [15:0] fail_load, fail_bit, s_fail_load, s_fail_bit;
    logic [5:0]  fail_chains, s_fail_chains;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    logic [5:0] pat [8];

    logic       obs_test_en, obs_scan_en, obs_clk_en, obs_ready, obs_done, obs_busy;
    logic [5:0] obs_sdi;
    logic [1:0] obs_state;

    always #5 clk = ~clk;

    scan_pattern_driver #(.NUM_CHAINS(6), .LEN_W(16), .CNT_W(16)) u_dut (
        .clk(clk), .ext_rst_n(ext_rst_n), .start(start), .abort(abort),
        .chain_len(chain_len), .num_loads(num_loads),
        .beat_valid(beat_valid), .beat_ready(beat_ready),
        .beat_si(beat_si), .beat_exp(beat_exp), .beat_mask(beat_mask), .sdo(sdo),
        .test_en(test_en), .scan_en(scan_en), .sdi(sdi), .scan_clk_en(scan_clk_en),
        .busy(busy), .done(done), .mismatch_cnt(mismatch_cnt), .fsm_state(fsm_state)
`ifdef SCAN_DRIVER_FAIL_LOG_EN
        , .fail_seen(fail_seen), .fail_load(fail_load), .fail_bit(fail_bit), .fail_chains(fail_chains)
`endif
    );

    scan_pattern_driver #(.NUM_CHAINS(6), .LEN_W(16), .CNT_W(2)) u_sat (
        .clk(clk), .ext_rst_n(ext_rst_n), .start(start), .abort(abort),
        .chain_len(chain_len), .num_loads(num_loads),
        .beat_valid(beat_valid), .beat_ready(s_beat_ready),
        .beat_si(beat_si), .beat_exp(beat_exp), .beat_mask(beat_mask), .sdo(sdo),
        .test_en(s_test_en), .scan_en(s_scan_en), .sdi(s_sdi), .scan_clk_en(s_scan_clk_en),
        .busy(s_busy), .done(s_done), .mismatch_cnt(s_mismatch_cnt), .fsm_state(s_fsm_state)
`ifdef SCAN_DRIVER_FAIL_LOG_EN
        , .fail_seen(s_fail_seen), .fail_load(s_fail_load), .fail_bit(s_fail_bit), .fail_chains(s_fail_chains)
`endif
    );

    // Driver tasks: inputs change 1 time unit after the edge, outputs are sampled 1 unit later.
    task automatic sample();
        obs_state   = fsm_state;
        obs_test_en = test_en;
        obs_scan_en = scan_en;
        obs_clk_en  = scan_clk_en;
        obs_ready   = beat_ready;
        obs_done    = done;
        obs_busy    = busy;
        obs_sdi     = sdi;
    endtask

    task automatic start_session(input logic [15:0] len, input logic [15:0] loads);
        @(posedge clk); #1;
        chain_len = len;
        num_loads = loads;
        start     = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic drive_beat(input logic [5:0] si, input logic [5:0] ex,
                              input logic [5:0] mk, input logic [5:0] so);
        beat_si    = si;
        beat_exp   = ex;
        beat_mask  = mk;
        sdo        = so;
        beat_valid = 1'b1;
        #1 sample();
        @(posedge clk); #1;
        beat_valid = 1'b0;
    endtask

    task automatic drive_idle();
        beat_valid = 1'b0;
        #1 sample();
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        ext_rst_n = 1'b0;
        #3;
        tests_run++;
        if ({test_en, scan_en, scan_clk_en, beat_ready, busy, done, sdi, mismatch_cnt, fsm_state} !== 30'd0) begin
            tests_failed++;
            $display("FAIL reset_outputs: got %b required all zero",
                     {test_en, scan_en, scan_clk_en, beat_ready, busy, done, sdi, mismatch_cnt, fsm_state});
        end
        @(posedge clk); @(posedge clk); #1;
        ext_rst_n = 1'b1;
    endtask

    task automatic test_basic();
        start_session(16'd4, 16'd2);
        for (int i = 0; i < 8; i++) begin
            drive_beat(pat[i], pat[i], 6'h3F, pat[i]);
            tests_run++;
            if ({obs_state, obs_test_en, obs_scan_en, obs_clk_en, obs_ready, obs_sdi} !== {2'd1, 4'b1111, pat[i]}) begin
                tests_failed++;
                $display("FAIL basic_beat%0d: got %b required %b", i,
                         {obs_state, obs_test_en, obs_scan_en, obs_clk_en, obs_ready, obs_sdi}, {2'd1, 4'b1111, pat[i]});
            end
            if (i == 3) begin
                drive_idle();
                tests_run++;
                if ({obs_state, obs_test_en, obs_scan_en, obs_clk_en, obs_ready} !== 6'b10_1010) begin
                    tests_failed++;
                    $display("FAIL basic_capture: got %b required 101010",
                             {obs_state, obs_test_en, obs_scan_en, obs_clk_en, obs_ready});
                end
            end
        end
        drive_idle();
        tests_run++;
        if ({obs_state, obs_done, obs_test_en, obs_scan_en, obs_clk_en} !== 6'b11_1100) begin
            tests_failed++;
            $display("FAIL basic_done: got %b required 111100", {obs_state, obs_done, obs_test_en, obs_scan_en, obs_clk_en});
        end
        tests_run++;
        if ({busy, done, test_en, mismatch_cnt} !== 19'd0) begin
            tests_failed++;
            $display("FAIL basic_idle: busy=%b done=%b test_en=%b cnt=%0d required 0/0/0/0", busy, done, test_en, mismatch_cnt);
        end
    endtask

    task automatic test_mismatch();
        start_session(16'd4, 16'd2);
        for (int i = 0; i < 8; i++) begin
            drive_beat(pat[i], pat[i], 6'h3F, (i == 5) ? (pat[i] ^ 6'h09) : pat[i]);
            if (i == 3) drive_idle();
        end
        drive_idle();
        tests_run++;
        if (mismatch_cnt !== 16'd2) begin
            tests_failed++;
            $display("FAIL mismatch_count: got %0d required 2", mismatch_cnt);
        end
`ifdef SCAN_DRIVER_FAIL_LOG_EN
        tests_run++;
        if ({fail_seen, fail_load, fail_bit, fail_chains} !== {1'b1, 16'd1, 16'd1, 6'h09}) begin
            tests_failed++;
            $display("FAIL fail_log: seen=%b load=%0d bit=%0d chains=%h required 1/1/1/09",
                     fail_seen, fail_load, fail_bit, fail_chains);
        end
`endif
    endtask

    task automatic test_mask();
        start_session(16'd4, 16'd2);
        for (int i = 0; i < 8; i++) begin
            if (i < 4) drive_beat(pat[i], pat[i], 6'h00, ~pat[i]);
            else       drive_beat(pat[i], pat[i], 6'h3F, pat[i]);
            if (i == 3) drive_idle();
        end
        drive_idle();
        tests_run++;
        if (mismatch_cnt !== 16'd0) begin
            tests_failed++;
            $display("FAIL mask_zero: got %0d required 0", mismatch_cnt);
        end
    endtask

    task automatic test_stall();
        start_session(16'd4, 16'd2);
        drive_beat(pat[0], pat[0], 6'h3F, pat[0]);
        drive_beat(pat[1], pat[1], 6'h3F, pat[1]);
        for (int s = 0; s < 3; s++) begin
            drive_idle();
            tests_run++;
            if ({obs_state, obs_clk_en, obs_ready, obs_sdi} !== {2'd1, 1'b0, 1'b1, pat[1]}) begin
                tests_failed++;
                $display("FAIL stall%0d: got %b required %b", s,
                         {obs_state, obs_clk_en, obs_ready, obs_sdi}, {2'd1, 1'b0, 1'b1, pat[1]});
            end
        end
        drive_beat(pat[2], pat[2], 6'h3F, pat[2]);
        drive_beat(pat[3], pat[3], 6'h3F, pat[3]);
        drive_idle();
        tests_run++;
        if (obs_state !== 2'd2) begin
            tests_failed++;
            $display("FAIL stall_capture: state %0d required 2", obs_state);
        end
        for (int i = 4; i < 8; i++) drive_beat(pat[i], pat[i], 6'h3F, pat[i]);
        drive_idle();
        tests_run++;
        if ({obs_done, obs_busy} !== 2'b11) begin
            tests_failed++;
            $display("FAIL stall_done: done=%b busy=%b required 1/1", obs_done, obs_busy);
        end
    endtask

    task automatic test_abort();
        start_session(16'd4, 16'd2);
        drive_beat(pat[0], pat[0], 6'h3F, pat[0] ^ 6'h01);
        drive_beat(pat[1], pat[1], 6'h3F, pat[1]);
        beat_si    = pat[2];
        beat_exp   = pat[2];
        sdo        = ~pat[2];
        beat_valid = 1'b1;
        abort      = 1'b1;
        #1;
        tests_run++;
        if ({beat_ready, scan_clk_en} !== 2'b00) begin
            tests_failed++;
            $display("FAIL abort_priority: ready=%b clk_en=%b required 0/0", beat_ready, scan_clk_en);
        end
        @(posedge clk); #1;
        abort      = 1'b0;
        beat_valid = 1'b0;
        tests_run++;
        if ({fsm_state, test_en, busy, mismatch_cnt} !== {2'd0, 1'b0, 1'b0, 16'd1}) begin
            tests_failed++;
            $display("FAIL abort_idle: state=%0d test_en=%b busy=%b cnt=%0d required 0/0/0/1",
                     fsm_state, test_en, busy, mismatch_cnt);
        end
        drive_idle();
        tests_run++;
        if (obs_done !== 1'b0) begin
            tests_failed++;
            $display("FAIL abort_no_done: got %b required 0", obs_done);
        end
        start_session(16'd4, 16'd0);
        drive_idle();
        tests_run++;
        if ({obs_state, obs_done, obs_test_en, obs_scan_en, obs_clk_en, mismatch_cnt} !== {6'b11_1100, 16'd1}) begin
            tests_failed++;
            $display("FAIL zero_loads_done: state=%0d done=%b te=%b se=%b ce=%b cnt=%0d required 3/1/1/0/0/1",
                     obs_state, obs_done, obs_test_en, obs_scan_en, obs_clk_en, mismatch_cnt);
        end
        tests_run++;
        if ({busy, done} !== 2'b00) begin
            tests_failed++;
            $display("FAIL zero_loads_end: busy=%b done=%b required 0/0", busy, done);
        end
    endtask

    task automatic test_saturate_and_async_reset();
        start_session(16'd4, 16'd2);
        drive_beat(pat[0], pat[0], 6'h3F, pat[0] ^ 6'h07);
        drive_beat(pat[1], pat[1], 6'h3F, pat[1] ^ 6'h30);
        tests_run++;
        if ({s_mismatch_cnt, mismatch_cnt} !== {2'd3, 16'd5}) begin
            tests_failed++;
            $display("FAIL saturate: small=%0d wide=%0d required 3/5", s_mismatch_cnt, mismatch_cnt);
        end
        beat_si    = pat[2];
        beat_exp   = pat[2];
        sdo        = pat[2];
        beat_valid = 1'b1;
        #2 ext_rst_n = 1'b0;
        #1;
        tests_run++;
        if ({test_en, scan_en, scan_clk_en, beat_ready, busy, done, sdi, mismatch_cnt, fsm_state} !== 30'd0) begin
            tests_failed++;
            $display("FAIL async_reset: got %b required all zero",
                     {test_en, scan_en, scan_clk_en, beat_ready, busy, done, sdi, mismatch_cnt, fsm_state});
        end
        beat_valid = 1'b0;
        @(posedge clk); #1;
        ext_rst_n = 1'b1;
    endtask

    initial begin
        pat        = '{6'h15, 6'h2A, 6'h3C, 6'h03, 6'h11, 6'h22, 6'h0F, 6'h30};
        start      = 1'b0;
        abort      = 1'b0;
        beat_valid = 1'b0;
        chain_len  = '0;
        num_loads  = '0;
        beat_si    = '0;
        beat_exp   = '0;
        beat_mask  = '0;
        sdo        = '0;
        test_reset();
        test_basic();
        test_mismatch();
        test_mask();
        test_stall();
        test_abort();
        test_saturate_and_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
